// File: rtl/riadd_stream.sv
`default_nettype none
// ============================================================================
//  Module   : riadd_stream
//  Purpose  : Multi-lane MSD-first online adder for radix-2^k signed-digit
//             operands. Every lane adds two digit streams with online delay 1.
//             A P-digit frame produces P+1 sum digits: the leading transfer
//             digit s_0, P-1 body digits and the trailing flush digit s_P.
//             All lanes share one FSM and one valid/ready handshake.
//  Optional : RIADD_RANGE_CHK_EN -- when defined, any accepted lane digit
//             outside {-A..A} sets the sticky err flag. When undefined, err
//             is tied low and no check logic is built.
//  Ports    : clk        clock
//             reset      asynchronous, active-high reset
//             in_valid   input digit pair present
//             in_ready   block accepts the input digit pair this cycle
//             in_last    accepted pair is the final digit of the frame
//             x_dig      LANES x N-bit x digits, lane i at [i*N +: N]
//             y_dig      LANES x N-bit y digits, same packing
//             out_valid  s_dig is valid
//             out_ready  downstream consumes the output digit
//             out_first  output digit is s_0 (transfer digit)
//             out_last   output digit is the final digit of the frame
//             s_dig      LANES x N-bit sum digits, each in {-A..A}
//             err        sticky input-range error
//  Revision : 1.0 - initial release
// ============================================================================
module riadd_stream #(
    parameter int RADIX = 4,
    parameter int A     = RADIX - 1,
    parameter int LANES = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic                                 in_last,
    input  logic [LANES*($clog2(RADIX)+1)-1:0]   x_dig,
    input  logic [LANES*($clog2(RADIX)+1)-1:0]   y_dig,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 out_first,
    output logic                                 out_last,
    output logic [LANES*($clog2(RADIX)+1)-1:0]   s_dig,
    output logic                                 err
);

    localparam int N = $clog2(RADIX) + 1;

    // Thresholds at the N+1-bit width of the raw digit-pair sum.
    localparam logic signed [N:0]   A_POS   = (N+1)'(A);
    localparam logic signed [N:0]   A_NEG   = (N+1)'(-A);
    // RADIX taken modulo 2^N: the interim digit always fits N bits, so the
    // subtraction/addition can be done in N-bit modular arithmetic.
    localparam logic [N-1:0]        R_MOD   = N'(RADIX);
    localparam logic signed [N-1:0] T_PLUS  = N'(1);
    localparam logic signed [N-1:0] T_MINUS = N'(-1);
    localparam logic signed [N-1:0] T_ZERO  = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   out_valid_q, out_valid_d;
    logic   out_first_q, out_first_d;
    logic   out_last_q,  out_last_d;

    logic   out_free;
    logic   accept;
    logic   load_flush;

    // The output register can take a new digit when empty or being drained.
    assign out_free   = !out_valid_q || out_ready;
    assign in_ready   = !reset && (state_q != ST_FLUSH) && out_free;
    assign accept     = in_valid && in_ready;
    assign load_flush = (state_q == ST_FLUSH) && out_free;

    // ------------------------------------------------------------------
    // Shared control: state and output-register flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (accept) begin
                    state_d = in_last ? ST_FLUSH : ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (out_free) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            out_valid_d = 1'b1;
            // The first accept of a frame always happens from IDLE.
            out_first_d = (state_q == ST_IDLE);
            out_last_d  = 1'b0;
        end else if (load_flush) begin
            out_valid_d = 1'b1;
            out_first_d = 1'b0;
            out_last_d  = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;

    // ------------------------------------------------------------------
    // Per-lane datapath
    // ------------------------------------------------------------------
`ifdef RIADD_RANGE_CHK_EN
    logic [LANES-1:0] lane_bad;
`endif

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lanes
        logic signed [N:0]   x_ext;
        logic signed [N:0]   y_ext;
        logic signed [N:0]   p_sum;
        logic signed [N-1:0] t_dig;
        logic signed [N-1:0] w_new;
        logic signed [N-1:0] w_q, w_d;
        logic signed [N-1:0] s_q, s_d;

        assign x_ext = {x_dig[gi*N+N-1], x_dig[gi*N +: N]};
        assign y_ext = {y_dig[gi*N+N-1], y_dig[gi*N +: N]};

        always_comb begin
            p_sum = x_ext + y_ext;
            t_dig = T_ZERO;
            w_new = p_sum[N-1:0];
            if (p_sum >= A_POS) begin
                t_dig = T_PLUS;
                w_new = p_sum[N-1:0] - R_MOD;
            end else if (p_sum <= A_NEG) begin
                t_dig = T_MINUS;
                w_new = p_sum[N-1:0] + R_MOD;
            end

            w_d = w_q;
            s_d = s_q;
            if (accept) begin
                // Emit previous interim digit plus the new transfer.
                s_d = w_q + t_dig;
                w_d = w_new;
            end else if (load_flush) begin
                s_d = w_q;
                w_d = '0;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                w_q <= '0;
                s_q <= '0;
            end else begin
                w_q <= w_d;
                s_q <= s_d;
            end
        end

        assign s_dig[gi*N +: N] = s_q;

`ifdef RIADD_RANGE_CHK_EN
        assign lane_bad[gi] = (x_ext > A_POS) || (x_ext < A_NEG) ||
                              (y_ext > A_POS) || (y_ext < A_NEG);
`endif
    end

    // ------------------------------------------------------------------
    // Sticky range error
    // ------------------------------------------------------------------
`ifdef RIADD_RANGE_CHK_EN
    logic err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (accept && (|lane_bad)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/riadd_stream.md
# riadd_stream

Multi-lane, MSD-first online adder for radix-2^k signed-digit operands with a valid/ready stream interface and frame delimiting. Each lane adds two digit streams with online delay 1 and emits P+1 sum digits for a P-digit frame, including the leading transfer digit and the trailing flush digit. It sits between MSDF operand sources and downstream online multipliers and accumulators, and can absorb backpressure.

## Interface
- RADIX, 4: power of two, ≥4.
- A, RADIX-1: digit bound, digit set {-A..A}; legal range ceil((RADIX+1)/2) ≤ A ≤ RADIX-1.
- LANES, 1: independent adder lanes sharing one handshake.
- N (localparam), $clog2(RADIX)+1: digit width, two's complement.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  input digit pair present.
- in_ready  out  1  block accepts the input digit pair this cycle.
- in_last  in  1  accepted pair is the final digit of the frame.
- x_dig  in  LANES*N  x digits; lane i is bits [i*N +: N].
- y_dig  in  LANES*N  y digits; same packing as x_dig.
- out_valid  out  1  s_dig is valid.
- out_ready  in  1  downstream consumes the output digit.
- out_first  out  1  output digit is s_0, the integer/transfer digit.
- out_last  out  1  output digit is the final digit of the frame.
- s_dig  out  LANES*N  sum digits, each in {-A..A}.
- err  out  1  sticky input-range error (see Configuration).

## Operation
- Accept: in_valid && in_ready.
- Per lane, for accepted digit j (j=1..P), with p = x_j + y_j computed at N+1 bits:
  - p ≥ A: t_j = 1, w_j = p - RADIX.
  - p ≤ -A: t_j = -1, w_j = p + RADIX.
  - otherwise: t_j = 0, w_j = p.
- The output digit is s_{j-1} = w_{j-1} + t_j, with w_0 = 0. After the last digit, s_P = w_P.
- |w| ≤ A-1 and |s| ≤ A are guaranteed for legal digits.
- The per-lane w register holds w_{j-1}.
- FSM states:
  - IDLE: no frame open, w = 0. An accept without last goes to RUN; an accept with last goes to FLUSH.
  - RUN: frame open. An accept with last goes to FLUSH.
  - FLUSH: the final digit is pending. When the output register is free, it loads s = w with out_last = 1, clears w to 0, and goes to IDLE.
- in_ready = (state != FLUSH) && (!out_valid || out_ready). in_ready is 0 while reset is asserted.
- out_first is set on the output produced by the first accept of a frame. This includes a single-digit frame, which emits t_1 (first), then w_1 (last).
- The output register holds s_dig, out_first, out_last and out_valid stable while out_valid && !out_ready.
- Lanes never interact. All lanes share the FSM and the handshake.

## Timing
- Reset values: out_valid = 0, s_dig = 0, out_first = 0, out_last = 0, err = 0, w = 0, state = IDLE.
- Latency: the digit accepted at edge c produces out_valid = 1 after edge c; its output is visible in cycle c+1.
- Throughput: one digit per cycle without backpressure. A P-digit frame occupies P+1 output cycles. The next frame's first accept can occur in the cycle after the FLUSH emission.
- The IDLE→FLUSH path needs no extra cycle: the flush digit follows the first-digit output on the next free output slot.
- Reset mid-frame aborts the frame. Partial w is discarded and no out_last is emitted.
- With out_ready held low, no input is accepted and no digit is lost or duplicated.

## Configuration
- RIADD_RANGE_CHK_EN defined:
  - Any accepted lane digit with |x| > A or |y| > A sets err = 1.
  - err is sticky until reset.
  - Datapath behaviour is unchanged.
- RIADD_RANGE_CHK_EN undefined: err is tied to 0, the check logic is absent, and the output for illegal digits is unspecified.

## Test plan
- RADIX=4, A=3, LANES=1. Input frame x=[3,3], y=[3,2] -> s=[1,3,1]: out_first on the 1, out_last on the final 1. Value 29/16.
- x=[-3,-2], y=[-2,-3] -> s=[-1,-2,-1]. Value -25/16.
- Single-digit frame x=[2], y=[1] -> s=[1,-1], with out_first on digit 0 and out_last on digit 1.
- Repeat the first scenario with out_ready low for 3 cycles after the first output -> s_dig is held, in_ready = 0, and the sequence is still [1,3,1].
- Assert reset after the first accept of [3,3]/[3,2], then send x=[1], y=[1] -> all outputs 0 during reset, then s=[0,2] with no residue.
- Send x=[-4], y=[0] -> err = 1 and stays 1 until reset with RIADD_RANGE_CHK_EN defined; err stays 0 without it. With LANES=2, lanes carrying the first and second scenarios produce both results independently.
